pulse_counter_mc: RTL
=====================

Name: pulse_counter_mc

Overview:
Multi-channel, debounced pulse counter for raw asynchronous inputs such as opto/relay lines.
Each channel synchronises its input, glitch-filters it with a runtime-programmable stability length, and detects the selected edge type. It counts edges in a wrap or saturating counter and supports atomic snapshot of all channels.
Sits between the pad inputs and the register/readout logic; replaces the single-channel fixed-filter counter.

Parameters:
N_CH, 4, number of independent channels (1..16)
CNT_WIDTH, 16, width of each event counter
FLT_WIDTH, 4, width of filter length and filter counter; max filter length 2^FLT_WIDTH-1
SYNC_STAGES, 2, synchroniser flops per input (2..3)

Ports:
i_clk  input  1  system clock
i_rst  input  1  reset, asynchronous, active-high
i_pulse  input  N_CH  raw asynchronous channel inputs
i_en  input  N_CH  per-channel count enable
i_clr  input  N_CH  per-channel synchronous clear of counter and overflow flag
i_flt_len  input  FLT_WIDTH  required stable cycles L; 0 treated as 1
i_edge_mode  input  2  00 rising, 01 falling, 10 both, 11 treated as rising
i_sat  input  1  1 = saturate at max, 0 = wrap
i_snap  input  1  snapshot strobe (all channels)
i_snap_clr  input  1  with i_snap: clear live counters after capture
o_cnt  output  N_CH*CNT_WIDTH  live counters, ch0 in LSBs
o_snap  output  N_CH*CNT_WIDTH  snapshot registers
o_snap_vld  output  1  one-cycle pulse, snapshot updated
o_ovf  output  N_CH  sticky overflow per channel

Behaviour:
- Reset state:
  - Asynchronous; all outputs 0.
  - Filter counters 0; filtered level s = 0; synchronisers 0.
  - Startup counter = 0.
- Startup:
  - For SYNC_STAGES+1 cycles after reset release, each s <= sync_out every cycle.
  - No events are counted during this window, so a line already high at reset never produces a spurious edge.
- Filter, per channel, each cycle:
  - If sync_out == s: filter counter <= 0.
  - Else filter counter increments.
  - When sync_out != s on L consecutive edges: s flips, filter counter <= 0, and the edge event fires on that same edge.
  - Filter counter never exceeds L-1.
  - A glitch shorter than L cycles resets the counter and produces no event.
- Disabled channel (i_en=0):
  - Filter counter held 0, s <= sync_out, no events.
  - Re-enable therefore never counts a change that happened while disabled.
- Edge select:
  - rising = s 0->1; falling = s 1->0; both = any flip.
  - Mode is sampled on the flip edge.
- Latency: raw level first captured at edge k (SYNC_STAGES=2) -> o_cnt updates at edge k+1+L.
- Counting:
  - Wrap mode: max -> 0 and o_ovf <= 1.
  - Sat mode: at all-ones, hold value; o_ovf <= 1 on each attempted increment.
- o_ovf is cleared only by i_clr or reset.
- Snapshot:
  - On i_snap, o_snap <= current o_cnt (pre-update value) for all channels simultaneously.
  - o_snap_vld = 1 on the following cycle for exactly one cycle.
  - With i_snap_clr: live counter <= 0, or 1 if an event fires that same cycle (no event lost).
- Priority per channel, same cycle:
  - i_clr > snapshot clear > increment.
  - i_clr with event -> counter 0, ovf 0.
  - i_clr with i_snap -> snapshot holds pre-clear value.
- Runtime change of i_flt_len:
  - Takes effect immediately.
  - If the filter counter is >= new L-1 and a difference persists, s flips on the next edge.
- Reset mid-operation: immediate asynchronous clear of everything, startup window re-entered.

Decomposition:
- Package pulse_cnt_pkg:
  - edge mode constants EDGE_RISE=2'b00, EDGE_FALL=2'b01, EDGE_BOTH=2'b10;
  - max channel and sync-stage limits.
- Sub-module pulse_filt_ch:
  - contents: synchroniser, filter counter, filtered level s, edge-event output;
  - instantiated N_CH times via generate.
- Counters, overflow, snapshot and startup logic live in the top.

Test Plan:
1. L=4, rising mode, ch0: clean 10-cycle high pulses x3 -> o_cnt[ch0]=3, increments at k+5 each; other channels 0.
2. L=4: 3-cycle glitches x5, then one 4-cycle high -> count 0 during glitches, then exactly 1.
3. Both-edges mode, L=1: square wave of 5 periods -> count 10. Falling mode with the same wave -> 5.
4. CNT_WIDTH=4 build:
   - wrap: 17 pulses -> cnt=1, o_ovf=1;
   - sat: 17 pulses -> cnt=15, o_ovf=1;
   - then i_clr -> cnt=0, ovf=0.
5. Snapshot with i_snap_clr asserted on the same cycle as a ch1 event, ch1 count=7 -> o_snap[ch1]=7, live=1, o_snap_vld high one cycle later.
6. Input held high through reset release, then i_rst pulse mid-pulse -> no count in the startup window, all outputs 0 immediately, counting resumes correctly after the window.

Source files
------------

// File: rtl/pulse_cnt_pkg.sv
// Shared definitions for the multi-channel pulse counter.
// Contents:
//   - edge-mode encodings for i_edge_mode (11 decodes as rising);
//   - build limits on channel count and synchroniser depth.
package pulse_cnt_pkg;

  localparam logic [1:0] EDGE_RISE = 2'b00;
  localparam logic [1:0] EDGE_FALL = 2'b01;
  localparam logic [1:0] EDGE_BOTH = 2'b10;

  localparam int MAX_CH   = 16;
  localparam int MIN_SYNC = 2;
  localparam int MAX_SYNC = 3;

endpackage

// File: rtl/pulse_counter_mc_if.sv
// Control/readout bundle of the multi-channel pulse counter.
// Inputs to the counter:
//   i_pulse, i_en, i_clr  per-channel raw line, count enable, clear
//   i_flt_len             filter stability length (0 acts as 1)
//   i_edge_mode           edge selection
//   i_sat                 saturate (1) or wrap (0)
//   i_snap, i_snap_clr    snapshot strobe, clear-after-capture
// Outputs from the counter:
//   o_cnt, o_snap         live and snapshot counters, ch0 in LSBs
//   o_snap_vld            one-cycle snapshot-updated pulse
//   o_ovf                 sticky per-channel overflow
// Modports: slave = counter side, master = driver/readout side.
interface pulse_counter_mc_if #(
  parameter int N_CH      = 4,
  parameter int CNT_WIDTH = 16,
  parameter int FLT_WIDTH = 4
);
  import pulse_cnt_pkg::*;

  logic [N_CH-1:0]           i_pulse;
  logic [N_CH-1:0]           i_en;
  logic [N_CH-1:0]           i_clr;
  logic [FLT_WIDTH-1:0]      i_flt_len;
  logic [1:0]                i_edge_mode;
  logic                      i_sat;
  logic                      i_snap;
  logic                      i_snap_clr;
  logic [N_CH*CNT_WIDTH-1:0] o_cnt;
  logic [N_CH*CNT_WIDTH-1:0] o_snap;
  logic                      o_snap_vld;
  logic [N_CH-1:0]           o_ovf;

  modport slave (
    input  i_pulse, i_en, i_clr, i_flt_len, i_edge_mode, i_sat, i_snap, i_snap_clr,
    output o_cnt, o_snap, o_snap_vld, o_ovf
  );

  modport master (
    output i_pulse, i_en, i_clr, i_flt_len, i_edge_mode, i_sat, i_snap, i_snap_clr,
    input  o_cnt, o_snap, o_snap_vld, o_ovf
  );

endinterface

// File: rtl/pulse_filt_ch.sv
// One channel front end: synchroniser, glitch filter and edge detector.
// Ports:
//   i_clk, i_rst     clock, asynchronous active-high reset
//   i_pulse          raw asynchronous line
//   i_en             channel enable; when low the filter tracks the line silently
//   i_startup        high during the post-reset window; tracks silently as well
//   i_flt_len        stable cycles required (0 acts as 1)
//   i_edge_mode      edge selection, sampled when the filtered level flips
//   o_evt            combinational event, valid on the edge where the level flips
module pulse_filt_ch
  import pulse_cnt_pkg::*;
#(
  parameter int FLT_WIDTH   = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_pulse,
  input  logic                 i_en,
  input  logic                 i_startup,
  input  logic [FLT_WIDTH-1:0] i_flt_len,
  input  logic [1:0]           i_edge_mode,
  output logic                 o_evt
);

  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   sync_out;
  logic                   lvl_q, lvl_nxt;
  logic [FLT_WIDTH-1:0]   fcnt_q, fcnt_nxt;
  logic [FLT_WIDTH:0]     fcnt_inc;
  logic [FLT_WIDTH:0]     len_eff;
  logic                   flip;

  assign sync_out = sync_p0[SYNC_STAGES-1];
  assign len_eff  = (i_flt_len == '0) ? (FLT_WIDTH+1)'(1) : {1'b0, i_flt_len};
  assign fcnt_inc = {1'b0, fcnt_q} + 1'b1;

  // Synchroniser stage boundary
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) sync_p0 <= '0;
    else       sync_p0 <= {sync_p0[SYNC_STAGES-2:0], i_pulse};
  end

  // The flip condition is fcnt+1 >= L, so lowering L at runtime below the
  // current count flips on the very next edge if the difference persists.
  always_comb begin
    lvl_nxt  = lvl_q;
    fcnt_nxt = fcnt_q;
    flip     = 1'b0;
    if (i_startup || !i_en) begin
      lvl_nxt  = sync_out;
      fcnt_nxt = '0;
    end else if (sync_out == lvl_q) begin
      fcnt_nxt = '0;
    end else if (fcnt_inc >= len_eff) begin
      lvl_nxt  = sync_out;
      fcnt_nxt = '0;
      flip     = 1'b1;
    end else begin
      fcnt_nxt = fcnt_inc[FLT_WIDTH-1:0];
    end
  end

  always_comb begin
    o_evt = 1'b0;
    case (i_edge_mode)
      EDGE_FALL: o_evt = flip & ~sync_out;
      EDGE_BOTH: o_evt = flip;
      default:   o_evt = flip & sync_out;
    endcase
  end

  // Filter state boundary
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      lvl_q  <= 1'b0;
      fcnt_q <= '0;
    end else begin
      lvl_q  <= lvl_nxt;
      fcnt_q <= fcnt_nxt;
    end
  end

endmodule

// File: rtl/pulse_counter_mc.sv
// Multi-channel debounced pulse counter.
// Ports:
//   i_clk, i_rst  clock, asynchronous active-high reset
//   bus           pulse_counter_mc_if.slave: raw lines, enables, clears,
//                 filter length, edge mode, sat/wrap, snapshot control;
//                 live counters, snapshot, snapshot valid, overflow flags
// Startup: for SYNC_STAGES+1 cycles after reset release every filter tracks
// its synchronised line without producing events, so a line already high at
// reset is never counted.
module pulse_counter_mc
  import pulse_cnt_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int CNT_WIDTH   = 16,
  parameter int FLT_WIDTH   = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                i_clk,
  input  logic                i_rst,
  pulse_counter_mc_if.slave   bus
);

  localparam logic [2:0] SU_LEN = 3'(SYNC_STAGES + 1);

  logic [2:0]                su_cnt;
  logic                      startup;
  logic [N_CH-1:0]           evt;
  logic [CNT_WIDTH-1:0]      cnt_q [N_CH];
  logic                      ovf_q [N_CH];
  logic [N_CH*CNT_WIDTH-1:0] cnt_flat;
  logic [N_CH-1:0]           ovf_flat;
  logic [N_CH*CNT_WIDTH-1:0] snap_q;
  logic                      snap_vld_p1;

  // Returns {overflow, next}; at all-ones either holds or wraps to zero.
  function automatic logic [CNT_WIDTH:0] cnt_step(input logic [CNT_WIDTH-1:0] v,
                                                  input logic sat);
    if (&v) return {1'b1, (sat ? v : {CNT_WIDTH{1'b0}})};
    else    return {1'b0, CNT_WIDTH'(v + 1'b1)};
  endfunction

  assign startup = (su_cnt < SU_LEN);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)        su_cnt <= '0;
    else if (startup) su_cnt <= su_cnt + 1'b1;
  end

  for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
    logic [CNT_WIDTH:0] step;

    pulse_filt_ch #(
      .FLT_WIDTH   (FLT_WIDTH),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_filt (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_pulse     (bus.i_pulse[ch]),
      .i_en        (bus.i_en[ch]),
      .i_startup   (startup),
      .i_flt_len   (bus.i_flt_len),
      .i_edge_mode (bus.i_edge_mode),
      .o_evt       (evt[ch])
    );

    assign step = cnt_step(cnt_q[ch], bus.i_sat);

    // Counter boundary: clear beats snapshot-clear beats increment
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        cnt_q[ch] <= '0;
        ovf_q[ch] <= 1'b0;
      end else if (bus.i_clr[ch]) begin
        cnt_q[ch] <= '0;
        ovf_q[ch] <= 1'b0;
      end else if (bus.i_snap && bus.i_snap_clr) begin
        cnt_q[ch] <= CNT_WIDTH'(evt[ch]);
      end else if (evt[ch]) begin
        cnt_q[ch] <= step[CNT_WIDTH-1:0];
        if (step[CNT_WIDTH]) ovf_q[ch] <= 1'b1;
      end
    end
  end

  always_comb begin
    cnt_flat = '0;
    ovf_flat = '0;
    for (int i = 0; i < N_CH; i++) begin
      cnt_flat[i*CNT_WIDTH +: CNT_WIDTH] = cnt_q[i];
      ovf_flat[i]                        = ovf_q[i];
    end
  end

  // Snapshot boundary: captures the pre-update live value of every channel
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      snap_q      <= '0;
      snap_vld_p1 <= 1'b0;
    end else begin
      snap_vld_p1 <= bus.i_snap;
      if (bus.i_snap) snap_q <= cnt_flat;
    end
  end

  assign bus.o_cnt      = cnt_flat;
  assign bus.o_ovf      = ovf_flat;
  assign bus.o_snap     = snap_q;
  assign bus.o_snap_vld = snap_vld_p1;

endmodule
